// File: rtl/fabric_instr_dispatcher.sv
// Streams a program of instruction words onto per-row fabric buses, calls every loaded row,
// then waits for each called row to return (optionally bounded by a timeout).
module fabric_instr_dispatcher #(
  parameter int unsigned ROWS             = 2,
  parameter int unsigned INSTR_DATA_WIDTH = 32,
  parameter int unsigned INSTR_ADDR_WIDTH = 4,
  parameter int unsigned INSTR_HOPS_WIDTH = 4,
  parameter int unsigned ROW_W            = (ROWS > 1) ? $clog2(ROWS) : 1,
  parameter int unsigned TIMEOUT_WIDTH    = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic                                   s_valid,
  output logic                                   s_ready,
  input  logic [ROW_W-1:0]                       s_row,
  input  logic [INSTR_ADDR_WIDTH-1:0]            s_addr,
  input  logic [INSTR_HOPS_WIDTH-1:0]            s_hops,
  input  logic [INSTR_DATA_WIDTH-1:0]            s_data,
  input  logic                                   s_last,
  input  logic [TIMEOUT_WIDTH-1:0]               timeout_limit,
  output logic [ROWS-1:0][INSTR_DATA_WIDTH-1:0]  instr_data_out,
  output logic [ROWS-1:0][INSTR_ADDR_WIDTH-1:0]  instr_addr_out,
  output logic [ROWS-1:0][INSTR_HOPS_WIDTH-1:0]  instr_hops_out,
  output logic [ROWS-1:0]                        instr_en_out,
  output logic [ROWS-1:0]                        call,
  input  logic [ROWS-1:0]                        ret,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   timeout,
  output logic                                   bad_row
);

  typedef enum logic [2:0] {StIdle, StLoad, StCall, StWait, StFin} state_e;

  state_e r_state, w_state_next;

  logic [ROWS-1:0][INSTR_DATA_WIDTH-1:0] r_data;
  logic [ROWS-1:0][INSTR_ADDR_WIDTH-1:0] r_addr;
  logic [ROWS-1:0][INSTR_HOPS_WIDTH-1:0] r_hops;
  logic [ROWS-1:0]                       r_en;
  logic [ROWS-1:0]                       r_call;
  logic [ROWS-1:0]                       r_row_mask;
  logic [ROWS-1:0]                       r_ret_seen;
  logic [ROWS-1:0]                       r_prev_ret;
  logic [TIMEOUT_WIDTH-1:0]              r_cnt;
  logic                                  r_timeout;
  logic                                  r_bad_row;

  logic                     w_accept;
  logic                     w_row_ok;
  logic [ROWS-1:0]          w_row_bit;
  logic [ROWS-1:0]          w_mask_next;
  logic [ROWS-1:0]          w_seen;
  logic                     w_complete;
  logic                     w_tmo_hit;
  logic [TIMEOUT_WIDTH-1:0] w_limit_m1;

  always_comb begin
    w_accept = (r_state == StLoad) && s_valid;
    w_row_ok = int'(s_row) < int'(ROWS);
    for (int r = 0; r < int'(ROWS); r++) begin
      w_row_bit[r] = w_row_ok && (int'(s_row) == r);
    end
    w_mask_next = r_row_mask | (w_accept ? w_row_bit : '0);
    // Only a fresh low-to-high transition on a called row counts as a return.
    w_seen      = r_ret_seen | (ret & ~r_prev_ret & r_row_mask);
    w_complete  = (w_seen & r_row_mask) == r_row_mask;
    w_limit_m1  = timeout_limit - TIMEOUT_WIDTH'(1);
    w_tmo_hit   = (timeout_limit != '0) && (r_cnt == w_limit_m1);
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: if (start) w_state_next = StLoad;
      StLoad: begin
        if (w_accept && s_last) w_state_next = (w_mask_next != '0) ? StCall : StFin;
      end
      StCall: w_state_next = StWait;
      StWait: if (w_complete || w_tmo_hit) w_state_next = StFin;
      StFin:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_data     <= '0;
      r_addr     <= '0;
      r_hops     <= '0;
      r_en       <= '0;
      r_call     <= '0;
      r_row_mask <= '0;
      r_ret_seen <= '0;
      r_prev_ret <= '0;
      r_cnt      <= '0;
      r_timeout  <= 1'b0;
      r_bad_row  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_en       <= '0;
      r_call     <= '0;
      r_prev_ret <= ret;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_row_mask <= '0;
            r_ret_seen <= '0;
            r_timeout  <= 1'b0;
            r_bad_row  <= 1'b0;
          end
        end
        StLoad: begin
          if (w_accept) begin
            r_row_mask <= w_mask_next;
            r_en       <= w_row_bit;
            if (!w_row_ok) r_bad_row <= 1'b1;
            for (int r = 0; r < int'(ROWS); r++) begin
              if (w_row_bit[r]) begin
                r_data[r] <= s_data;
                r_addr[r] <= s_addr;
                r_hops[r] <= s_hops;
              end
            end
          end
        end
        StCall: begin
          // Call is registered so the last instruction strobe leads it by a cycle.
          r_call <= r_row_mask;
          r_cnt  <= '0;
        end
        StWait: begin
          r_ret_seen <= w_seen;
          if (!w_complete) begin
            if (w_tmo_hit) r_timeout <= 1'b1;
            if (r_cnt != '1) r_cnt <= r_cnt + TIMEOUT_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign s_ready        = (r_state == StLoad);
  assign busy           = (r_state != StIdle);
  assign done           = (r_state == StFin);
  assign instr_data_out = r_data;
  assign instr_addr_out = r_addr;
  assign instr_hops_out = r_hops;
  assign instr_en_out   = r_en;
  assign call           = r_call;
  assign timeout        = r_timeout;
  assign bad_row        = r_bad_row;

endmodule
